dma_done_ctrl: RTL and testbench
================================

Name: dma_done_ctrl

Overview:
- Completion-side counterpart of the DMA start controller. The start controller arbitrates pending buffer-descriptor (BD) start requests and issues one BD number to the transfer engine.
- This block accepts BD completion and error reports coming back from the transfer engine and queues them in order.
- It presents the queue head to the register/interrupt interface, drives a pop-acknowledged interrupt line, and returns a one-hot "BD free" pulse towards the start side.

Parameters:
- NUM_INT_BDS, 4, number of internal buffer descriptors.
- BD_ID_WIDTH, 2, width of a BD number; must satisfy 2**BD_ID_WIDTH >= NUM_INT_BDS.
- QUEUE_DEPTH, 4, completion FIFO entries; power of two, at least 2.
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- CLOCK  in  1  single block clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DONE_VALID  in  1  transfer engine presents a completion report.
- DONE_BD  in  BD_ID_WIDTH  BD number of the report.
- DONE_ERR  in  1  report carries an AXI error (SLVERR/DECERR).
- DONE_READY  out  1  report accepted this cycle when DONE_VALID & DONE_READY.
- INT_POP  in  1  single-cycle pulse from a register read that pops the queue head.
- HEAD_VALID  out  1  queue non-empty.
- HEAD_BD  out  BD_ID_WIDTH  BD number at the queue head.
- HEAD_ERR  out  1  error flag at the queue head.
- QUEUE_LEVEL  out  clog2(QUEUE_DEPTH)+1  current number of queue entries.
- INTERRUPT  out  1  level interrupt to the host.
- BD_FREE  out  NUM_INT_BDS  one-hot pulse that frees a BD slot on the start side.
- ERR_CNT  out  CNT_WIDTH  saturating count of accepted error reports.

Behaviour:
- Reset (asynchronous, RESET=1):
  - Queue is emptied (pointers and level go to 0) and the FSM goes to IDLE.
  - All outputs are 0 except DONE_READY, which is 1.
  - Reset may assert mid-operation; any queued entries are discarded.
- Queue:
  - FIFO of {err, bd}.
  - DONE_READY = (level != QUEUE_DEPTH). This is registered-state based and has no combinational path from INT_POP.
  - Push on DONE_VALID & DONE_READY.
  - Pop on INT_POP & HEAD_VALID. INT_POP when empty is ignored, with no underflow.
  - Simultaneous push and pop: level is unchanged and both pointers advance.
  - When full, a push is refused even if INT_POP is high in the same cycle. The engine must hold DONE_VALID until it is accepted.
  - Pointers wrap modulo QUEUE_DEPTH.
  - HEAD_* outputs are driven from the read-pointer entry and are valid whenever HEAD_VALID=1. They are don't-care when empty, but held stable.
  - DONE_BD >= NUM_INT_BDS is still queued; the BD_FREE pulse for it is suppressed.
- BD_FREE:
  - Registered. On the cycle after a push, bit [DONE_BD] = 1 for exactly one cycle; otherwise all bits are 0.
  - At most one bit is ever set.
- ERR_CNT:
  - Increments on each accepted push with DONE_ERR=1.
  - Saturates at all-ones; it does not wrap.
  - Cleared only by reset.
- Interrupt FSM (registered, INTERRUPT = state==PEND):
  - IDLE: if level != 0, go to PEND.
  - PEND: on an accepted pop, go to HOLD.
  - HOLD: INTERRUPT is 0 for exactly one cycle, giving the host an edge to re-detect. Next state is PEND if the level after this cycle is non-zero, otherwise IDLE.
  - A push during HOLD is counted and is seen in that cycle's level evaluation.
- Latency:
  - Push to HEAD_VALID: 1 cycle.
  - Push into an empty queue to INTERRUPT: 2 cycles (level registers, then FSM).
  - Pop to INTERRUPT low: 1 cycle.

Decomposition:
- Shared package for the DMA controller:
  - Constants for NUM_INT_BDS and BD_ID_WIDTH defaults.
  - Queue entry typedef {err, bd}.
  - FSM state encoding: IDLE=2'd0, PEND=2'd1, HOLD=2'd2.
  - A clog2 function.
- One natural sub-module, dma_done_fifo: a generic synchronous FIFO with push/pop, full/empty and level outputs. The top level holds the FSM, BD_FREE decode and ERR_CNT.

Test Plan:
- Reset mid-queue:
  - Stimulus: push 3 entries, then assert RESET.
  - Required: immediately HEAD_VALID=0, QUEUE_LEVEL=0, INTERRUPT=0, ERR_CNT=0, DONE_READY=1, with no clock edge needed.
- Single completion:
  - Stimulus: push BD=2, ERR=0.
  - Required: next cycle BD_FREE=4'b0100 for one cycle and HEAD_BD=2; INTERRUPT=1 two cycles after the push. INT_POP then gives INTERRUPT=0 and IDLE.
- Fill and order:
  - Stimulus: push BDs 0,1,2,3 back-to-back.
  - Required: DONE_READY=0 with level 4; a 5th DONE_VALID is stalled. Pops return 0,1,2,3 in order; after the first pop, DONE_READY=1 and the stalled report is accepted.
- Simultaneous push and pop:
  - Stimulus: at level 2, assert push and pop together.
  - Required: level stays 2 and the head advances. FSM goes PEND→HOLD (INTERRUPT 0 for one cycle)→PEND.
- Error count and saturation:
  - Stimulus: with CNT_WIDTH=2, push 5 reports with ERR=1, popping as needed.
  - Required: ERR_CNT sequence 1,2,3,3,3; HEAD_ERR=1 for each entry.
- Pop when empty and out-of-range BD:
  - Stimulus: INT_POP while empty, then push DONE_BD=3 with NUM_INT_BDS=3.
  - Required: the pop does not change state; the push is queued with BD_FREE=0.

Source files
------------

// File: rtl/dma_done_ctrl_pkg.sv
// Shared definitions for the DMA controller: default BD sizing, completion
// queue entry layout, interrupt FSM encoding and a constant clog2 helper.
package dma_done_ctrl_pkg;

    localparam int DEF_NUM_INT_BDS = 4;
    localparam int DEF_BD_ID_WIDTH = 2;

    // One completion report as it sits in the queue
    typedef struct packed {
        logic                       err;
        logic [DEF_BD_ID_WIDTH-1:0] bd;
    } done_entry_t;

    // Interrupt handshake states
    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_PEND = 2'd1,
        IRQ_HOLD = 2'd2
    } irq_state_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dma_done_fifo.sv
// Generic synchronous FIFO with level output. The head entry is read
// straight from storage so it is visible the cycle after it is written.
module dma_done_fifo
    import dma_done_ctrl_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             push_ok;
    logic             pop_ok;

    // A full queue refuses pushes even when a pop happens in the same cycle
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign full  = (level_reg == FULL_LEVEL);
    assign empty = (level_reg == '0);
    assign level = level_reg;
    assign rdata = mem[rd_ptr_reg];

    // Entry storage; contents are not cleared by reset
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/dma_done_ctrl.sv
// Completion-side DMA controller: queues BD completion reports, exposes the
// queue head, raises a pop-acknowledged interrupt, returns BD-free pulses to
// the start side and counts error completions.
module dma_done_ctrl
    import dma_done_ctrl_pkg::*;
#(
    parameter int NUM_INT_BDS  = DEF_NUM_INT_BDS,
    parameter int BD_ID_WIDTH  = DEF_BD_ID_WIDTH,
    parameter int QUEUE_DEPTH  = 4,
    parameter int CNT_WIDTH    = 8,
    localparam int LVL_WIDTH   = clog2(QUEUE_DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   done_valid,
    input  logic [BD_ID_WIDTH-1:0] done_bd,
    input  logic                   done_err,
    output logic                   done_ready,
    input  logic                   int_pop,
    output logic                   head_valid,
    output logic [BD_ID_WIDTH-1:0] head_bd,
    output logic                   head_err,
    output logic [LVL_WIDTH-1:0]   queue_level,
    output logic                   interrupt,
    output logic [NUM_INT_BDS-1:0] bd_free,
    output logic [CNT_WIDTH-1:0]   err_cnt
);

    localparam logic [LVL_WIDTH-1:0] LVL_ONE = LVL_WIDTH'(1);

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [BD_ID_WIDTH:0]   fifo_rdata;
    logic                   push;
    logic                   pop;
    logic                   nonempty_next;
    irq_state_t             state_reg;
    logic                   interrupt_reg;
    logic [NUM_INT_BDS-1:0] bd_free_reg;
    logic [NUM_INT_BDS-1:0] bd_free_next;
    logic [CNT_WIDTH-1:0]   err_cnt_reg;

    // Ready depends only on registered level, never on int_pop
    assign done_ready = ~fifo_full;
    assign head_valid = ~fifo_empty;
    assign push       = done_valid & ~fifo_full;
    assign pop        = int_pop & ~fifo_empty;

    dma_done_fifo #(
        .WIDTH (BD_ID_WIDTH + 1),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({done_err, done_bd}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (queue_level)
    );

    assign head_err = fifo_rdata[BD_ID_WIDTH];
    assign head_bd  = fifo_rdata[BD_ID_WIDTH-1:0];

    // Whether the queue holds anything after this cycle's push/pop settle
    assign nonempty_next = push
                         | (queue_level > LVL_ONE)
                         | ((queue_level == LVL_ONE) & ~pop);

    // Interrupt FSM: HOLD drops the line for one cycle so the host sees a new edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IRQ_IDLE;
            interrupt_reg <= 1'b0;
        end else begin
            case (state_reg)
                IRQ_IDLE: begin
                    if (queue_level != '0) begin
                        state_reg     <= IRQ_PEND;
                        interrupt_reg <= 1'b1;
                    end
                end
                IRQ_PEND: begin
                    if (pop) begin
                        state_reg     <= IRQ_HOLD;
                        interrupt_reg <= 1'b0;
                    end
                end
                IRQ_HOLD: begin
                    if (nonempty_next) begin
                        state_reg     <= IRQ_PEND;
                        interrupt_reg <= 1'b1;
                    end else begin
                        state_reg     <= IRQ_IDLE;
                        interrupt_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IRQ_IDLE;
                    interrupt_reg <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt = interrupt_reg;

    // One-hot decode of the pushed BD; out-of-range numbers match no bit
    generate
        for (genvar gi = 0; gi < NUM_INT_BDS; gi++) begin : g_free
            assign bd_free_next[gi] = push & (done_bd == BD_ID_WIDTH'(gi));
        end
    endgenerate

    // BD-free pulse lasts exactly one cycle after the push
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bd_free_reg <= '0;
        end else begin
            bd_free_reg <= bd_free_next;
        end
    end

    assign bd_free = bd_free_reg;

    // Saturating count of accepted error completions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_reg <= '0;
        end else if (push && done_err && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_dma_done_ctrl.sv
// Randomised and directed bench for dma_done_ctrl. Two instances share the
// stimulus: the default configuration and a reduced one (3 BDs, 2-bit
// error counter) used for out-of-range BD and saturation behaviour.
module tb_dma_done_ctrl;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       done_valid;
    logic [1:0] done_bd;
    logic       done_err;
    logic       int_pop;

    logic       done_ready,  done_ready_s;
    logic       head_valid,  head_valid_s;
    logic [1:0] head_bd,     head_bd_s;
    logic       head_err,    head_err_s;
    logic [2:0] queue_level, queue_level_s;
    logic       interrupt,   interrupt_s;
    logic [3:0] bd_free;
    logic [2:0] bd_free_s;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;

    dma_done_ctrl u_dut (
        .clock       (clk),
        .reset       (rst),
        .done_valid  (done_valid),
        .done_bd     (done_bd),
        .done_err    (done_err),
        .done_ready  (done_ready),
        .int_pop     (int_pop),
        .head_valid  (head_valid),
        .head_bd     (head_bd),
        .head_err    (head_err),
        .queue_level (queue_level),
        .interrupt   (interrupt),
        .bd_free     (bd_free),
        .err_cnt     (err_cnt)
    );

    dma_done_ctrl #(
        .NUM_INT_BDS (3),
        .BD_ID_WIDTH (2),
        .QUEUE_DEPTH (4),
        .CNT_WIDTH   (2)
    ) u_dut_small (
        .clock       (clk),
        .reset       (rst),
        .done_valid  (done_valid),
        .done_bd     (done_bd),
        .done_err    (done_err),
        .done_ready  (done_ready_s),
        .int_pop     (int_pop),
        .head_valid  (head_valid_s),
        .head_bd     (head_bd_s),
        .head_err    (head_err_s),
        .queue_level (queue_level_s),
        .interrupt   (interrupt_s),
        .bd_free     (bd_free_s),
        .err_cnt     (err_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue plus the interrupt protocol and counters
    int q_bd[$];
    bit q_err[$];
    string m_state;
    int exp_free, exp_free_s;
    int exp_cnt, exp_cnt_s;
    int n_checks, n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_bd.delete();
        q_err.delete();
        m_state    = "IDLE";
        exp_free   = 0;
        exp_free_s = 0;
        exp_cnt    = 0;
        exp_cnt_s  = 0;
    endtask

    task automatic check_all();
        chk("ready",   done_ready,  q_bd.size() != DEPTH);
        chk("hvalid",  head_valid,  q_bd.size() != 0);
        chk("level",   queue_level, q_bd.size());
        chk("level_s", queue_level_s, q_bd.size());
        if (q_bd.size() != 0) begin
            chk("hbd",  head_bd,  q_bd[0]);
            chk("herr", head_err, q_err[0]);
        end
        chk("intr",   interrupt,   m_state == "PEND");
        chk("intr_s", interrupt_s, m_state == "PEND");
        chk("free",   bd_free,   exp_free);
        chk("free_s", bd_free_s, exp_free_s);
        chk("cnt",    err_cnt,   exp_cnt);
        chk("cnt_s",  err_cnt_s, exp_cnt_s);
    endtask

    // Drive one cycle (called at a falling edge), advance the model, check
    task automatic cycle(input bit v, input int bd, input bit err, input bit pop);
        bit acc_push, acc_pop;
        int lvl, lvl_after;
        string nxt;
        done_valid = v;
        done_bd    = 2'(bd);
        done_err   = err;
        int_pop    = pop;
        lvl       = q_bd.size();
        acc_push  = v && (lvl < DEPTH);
        acc_pop   = pop && (lvl > 0);
        lvl_after = lvl + int'(acc_push) - int'(acc_pop);
        nxt = m_state;
        if (m_state == "IDLE" && lvl != 0) nxt = "PEND";
        else if (m_state == "PEND" && acc_pop) nxt = "HOLD";
        else if (m_state == "HOLD") nxt = (lvl_after != 0) ? "PEND" : "IDLE";
        m_state = nxt;
        if (acc_pop) begin
            void'(q_bd.pop_front());
            void'(q_err.pop_front());
        end
        exp_free   = (acc_push && bd < 4) ? (1 << bd) : 0;
        exp_free_s = (acc_push && bd < 3) ? (1 << bd) : 0;
        if (acc_push) begin
            q_bd.push_back(bd);
            q_err.push_back(err);
            if (err) begin
                exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
                exp_cnt_s = (exp_cnt_s < 3) ? exp_cnt_s + 1 : 3;
            end
        end
        @(posedge clk);
        @(negedge clk);
        done_valid = 1'b0;
        int_pop    = 1'b0;
        check_all();
    endtask

    task automatic drain();
        int budget;
        budget = 16;
        while (q_bd.size() != 0 && budget > 0) begin
            cycle(0, 0, 0, 1);
            budget--;
        end
        chk("drain_budget", budget > 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        done_valid = 1'b0;
        done_bd    = 2'd0;
        done_err   = 1'b0;
        int_pop    = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single completion
        cycle(1, 2, 0, 0);
        chk("t1_free", bd_free, 4'b0100);
        chk("t1_hbd", head_bd, 2);
        chk("t1_intr0", interrupt, 0);
        cycle(0, 0, 0, 0);
        chk("t1_free_gone", bd_free, 0);
        chk("t1_intr1", interrupt, 1);
        cycle(0, 0, 0, 1);
        chk("t1_pop_intr", interrupt, 0);
        cycle(0, 0, 0, 0);
        chk("t1_idle_intr", interrupt, 0);

        // Error counting and saturation on the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            cycle(1, i % 4, 1, 1);
            chk("sat_cnt_s", err_cnt_s, (i < 3) ? i + 1 : 3);
            chk("sat_cnt", err_cnt, i + 1);
            chk("sat_herr", head_err, 1);
        end
        drain();

        // Fill, stall and order
        for (int i = 0; i < 4; i++) cycle(1, i, 0, 0);
        chk("fill_ready", done_ready, 0);
        chk("fill_level", queue_level, 4);
        cycle(1, 1, 0, 0);
        chk("stall_level", queue_level, 4);
        chk("fill_head0", head_bd, 0);
        cycle(1, 1, 0, 1);
        chk("popfull_level", queue_level, 3);
        chk("popfull_ready", done_ready, 1);
        cycle(1, 1, 0, 0);
        chk("stalled_acc", queue_level, 4);
        for (int i = 0; i < 4; i++) begin
            chk("order", head_bd, (i < 3) ? i + 1 : 1);
            cycle(0, 0, 0, 1);
        end
        drain();

        // Simultaneous push and pop at level 2
        cycle(1, 1, 0, 0);
        cycle(1, 2, 0, 0);
        cycle(0, 0, 0, 0);
        chk("sim_intr_pre", interrupt, 1);
        cycle(1, 3, 0, 1);
        chk("sim_level", queue_level, 2);
        chk("sim_head", head_bd, 2);
        chk("sim_intr_hold", interrupt, 0);
        cycle(0, 0, 0, 0);
        chk("sim_intr_back", interrupt, 1);
        drain();

        // Pop while empty, then out-of-range BD on the 3-BD instance
        cycle(0, 0, 0, 1);
        chk("popempty_level", queue_level, 0);
        cycle(1, 3, 0, 0);
        chk("oor_free_s", bd_free_s, 0);
        chk("oor_free", bd_free, 4'b1000);
        chk("oor_queued_s", head_bd_s, 3);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 2) == 0);
        end

        // Reset mid-queue, observed without a clock edge
        drain();
        for (int i = 0; i < 3; i++) cycle(1, i, 1, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_hvalid", head_valid, 0);
        chk("rst_level", queue_level, 0);
        chk("rst_intr", interrupt, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_ready", done_ready, 1);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
